inst_fetch: RTL

Instruction fetch unit for the RV32 core: holds the fetch PC, issues word reads to instruction memory with at most one request outstanding, and buffers returned words with their PCs in a small FIFO. The FIFO head drives the instruction decoder through a valid/ready handshake. A redirect from execute, branch or trap logic flushes the FIFO, discards any in-flight response and restarts fetch at the new PC.

---
 rtl/inst_fetch.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: RV32 instruction fetch unit.
// Holds the fetch PC and issues word reads to instruction memory, with at most
// one read outstanding. Returned words are buffered with their PCs in a small
// FIFO whose head feeds the decoder through a valid/ready handshake. A redirect
// flushes the FIFO, drops any in-flight response and restarts fetch.
// Build option: define FETCH_PREFETCH_EN for a 2-entry FIFO that keeps
// fetching while the decoder stalls. Without it the FIFO holds 1 entry.

module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_redirect,
   input  logic [31:0] i_redirectPC,
   output logic [31:0] o_memAddr,
   output logic        o_memRd,
   input  logic        i_memAck,
   input  logic        i_memRvalid,
   input  logic [31:0] i_memRdata,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   output logic        o_valid,
   input  logic        i_ready
);

`ifdef FETCH_PREFETCH_EN
   localparam int unsigned DEPTH = 2;
`else
   localparam int unsigned DEPTH = 1;
`endif
   localparam int unsigned CW = 2;
   localparam logic [31:0] WORD_MASK = ~32'h3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetchState;

   fetchState    state;
   logic [31:0]  fetchPC;
   logic         discard;

   // Two storage slots with toggling pointers; DEPTH only limits occupancy.
   logic [31:0]  instBuf [2];
   logic [31:0]  pcBuf   [2];
   logic         rdPtr;
   logic         wrPtr;
   logic [CW-1:0] count;

   logic         pushEn;
   logic         popEn;

   // A redirect wins over both the response push and the decoder pop.
   assign pushEn = (state == WAIT) && i_memRvalid && !discard && !i_redirect;
   assign popEn  = (count != '0) && i_ready && !i_redirect;

   assign o_valid = (count != '0);
   assign o_inst  = instBuf[rdPtr];
   assign o_pc    = pcBuf[rdPtr];

   // Request FSM: issues one read at a time and tracks the fetch PC.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state     <= IDLE;
         o_memRd   <= 1'b0;
         o_memAddr <= RESET_PC & WORD_MASK;
         fetchPC   <= RESET_PC & WORD_MASK;
         discard   <= 1'b0;
      end else if (i_redirect) begin
         fetchPC <= i_redirectPC & WORD_MASK;
         case (state)
            REQ: begin
               o_memRd <= 1'b0;
               if (i_memAck) begin
                  // Request already accepted: its response must be dropped.
                  discard <= 1'b1;
                  state   <= WAIT;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (i_memRvalid) begin
                  discard <= 1'b0;
                  state   <= IDLE;
               end else begin
                  discard <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end else begin
         case (state)
            IDLE: begin
               // Nothing is outstanding in IDLE, so only FIFO occupancy matters.
               if (count < CW'(DEPTH)) begin
                  state     <= REQ;
                  o_memRd   <= 1'b1;
                  o_memAddr <= fetchPC;
               end
            end
            REQ: begin
               if (i_memAck) begin
                  o_memRd <= 1'b0;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (i_memRvalid) begin
                  // A discarded response belongs to the old stream: no PC advance.
                  if (!discard) begin
                     fetchPC <= fetchPC + 32'd4;
                  end
                  discard <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               o_memRd <= 1'b0;
            end
         endcase
      end
   end

   // Instruction FIFO: push from memory responses, pop by the decoder.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         count <= '0;
         rdPtr <= 1'b0;
         wrPtr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            instBuf[i] <= '0;
            pcBuf[i]   <= '0;
         end
      end else if (i_redirect) begin
         count <= '0;
         rdPtr <= 1'b0;
         wrPtr <= 1'b0;
      end else begin
         if (pushEn) begin
            instBuf[wrPtr] <= i_memRdata;
            pcBuf[wrPtr]   <= fetchPC;
            wrPtr          <= ~wrPtr;
         end
         if (popEn) begin
            rdPtr <= ~rdPtr;
         end
         case ({pushEn, popEn})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
